// File: rtl/cache_mem_arbiter.sv
// Arbitrates the single external memory port between the I-cache and D-cache.
// D-cache wins by default; a starvation counter forces an I-cache grant after STARVE_LIMIT D grants.
module cache_mem_arbiter #(
   parameter int ADDR_W       = 28,
   parameter int DATA_W       = 128,
   parameter int STARVE_LIMIT = 4
) (
   input  logic              clk,
   input  logic              proc_reset,
   input  logic              ic_mem_read,
   input  logic [ADDR_W-1:0] ic_mem_addr,
   output logic [DATA_W-1:0] ic_mem_rdata,
   output logic              ic_mem_ready,
   input  logic              dc_mem_read,
   input  logic              dc_mem_write,
   input  logic [ADDR_W-1:0] dc_mem_addr,
   input  logic [DATA_W-1:0] dc_mem_wdata,
   output logic [DATA_W-1:0] dc_mem_rdata,
   output logic              dc_mem_ready,
   output logic              mem_read,
   output logic              mem_write,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ready
);

   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] GNT_I  = 3'd1;
   localparam logic [2:0] GNT_D  = 3'd2;
   localparam logic [2:0] RESP_I = 3'd3;
   localparam logic [2:0] RESP_D = 3'd4;

   localparam int               CNT_W      = $clog2(STARVE_LIMIT + 1);
   localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

   logic [2:0]        state_q,    state_d;
   logic [CNT_W-1:0]  starve_q,   starve_d;
   logic              memRead_q,  memRead_d;
   logic              memWrite_q, memWrite_d;
   logic [ADDR_W-1:0] memAddr_q,  memAddr_d;
   logic [DATA_W-1:0] memWdata_q, memWdata_d;
   logic [DATA_W-1:0] icRdata_q,  icRdata_d;
   logic [DATA_W-1:0] dcRdata_q,  dcRdata_d;
   logic              icReady_q,  icReady_d;
   logic              dcReady_q,  dcReady_d;

   logic dcPending;
   logic starveHit;

   assign dcPending = dc_mem_read | dc_mem_write;
   assign starveHit = (starve_q >= STARVE_MAX);

   // D wins unless the I-cache has been passed over STARVE_LIMIT times in a row.
   // A write-back takes precedence over a simultaneous D read; the read follows as its own grant.
   always_comb begin
      state_d    = state_q;
      starve_d   = starve_q;
      memRead_d  = memRead_q;
      memWrite_d = memWrite_q;
      memAddr_d  = memAddr_q;
      memWdata_d = memWdata_q;
      icRdata_d  = icRdata_q;
      dcRdata_d  = dcRdata_q;
      icReady_d  = 1'b0;
      dcReady_d  = 1'b0;

      case (state_q)
         IDLE: begin
            if (dcPending && (!starveHit || !ic_mem_read)) begin
               state_d   = GNT_D;
               memAddr_d = dc_mem_addr;
               if (dc_mem_write) begin
                  memWrite_d = 1'b1;
                  memRead_d  = 1'b0;
                  memWdata_d = dc_mem_wdata;
               end else begin
                  memWrite_d = 1'b0;
                  memRead_d  = 1'b1;
                  memWdata_d = '0;
               end
               if (ic_mem_read && !starveHit) begin
                  starve_d = starve_q + 1'b1;
               end
            end else if (ic_mem_read) begin
               state_d    = GNT_I;
               memAddr_d  = ic_mem_addr;
               memRead_d  = 1'b1;
               memWrite_d = 1'b0;
               memWdata_d = '0;
               starve_d   = '0;
            end
         end

         GNT_I: begin
            if (mem_ready) begin
               state_d   = RESP_I;
               memRead_d = 1'b0;
               icRdata_d = mem_rdata;
               icReady_d = 1'b1;
            end
         end

         GNT_D: begin
            if (mem_ready) begin
               state_d    = RESP_D;
               memRead_d  = 1'b0;
               memWrite_d = 1'b0;
               dcReady_d  = 1'b1;
               if (memRead_q) begin
                  dcRdata_d = mem_rdata;
               end
            end
         end

         RESP_I, RESP_D: begin
            state_d = IDLE;
         end

         default: begin
            state_d    = IDLE;
            memRead_d  = 1'b0;
            memWrite_d = 1'b0;
         end
      endcase
   end

   // Arbitration state; reset abandons any transaction in flight.
   always_ff @(posedge clk or posedge proc_reset) begin
      if (proc_reset) begin
         state_q  <= IDLE;
         starve_q <= '0;
      end else begin
         state_q  <= state_d;
         starve_q <= starve_d;
      end
   end

   // Memory-side request, latched at grant time and held for the whole grant.
   always_ff @(posedge clk or posedge proc_reset) begin
      if (proc_reset) begin
         memRead_q  <= 1'b0;
         memWrite_q <= 1'b0;
         memAddr_q  <= '0;
         memWdata_q <= '0;
      end else begin
         memRead_q  <= memRead_d;
         memWrite_q <= memWrite_d;
         memAddr_q  <= memAddr_d;
         memWdata_q <= memWdata_d;
      end
   end

   // Cache-side responses; read data holds until the next captured read for that cache.
   always_ff @(posedge clk or posedge proc_reset) begin
      if (proc_reset) begin
         icRdata_q <= '0;
         dcRdata_q <= '0;
         icReady_q <= 1'b0;
         dcReady_q <= 1'b0;
      end else begin
         icRdata_q <= icRdata_d;
         dcRdata_q <= dcRdata_d;
         icReady_q <= icReady_d;
         dcReady_q <= dcReady_d;
      end
   end

   assign mem_read     = memRead_q;
   assign mem_write    = memWrite_q;
   assign mem_addr     = memAddr_q;
   assign mem_wdata    = memWdata_q;
   assign ic_mem_rdata = icRdata_q;
   assign ic_mem_ready = icReady_q;
   assign dc_mem_rdata = dcRdata_q;
   assign dc_mem_ready = dcReady_q;

endmodule
